// File: rtl/fp16_row_accumulator.sv
// Row reduction engine: sums a stream of FP16 beats per row using an external
// pipelined half-precision adder, and reports sticky overflow/underflow/NaN flags.
module fp16_row_accumulator #(
  parameter int LATENCY = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_nan,
  output logic        add_clk_en,
  output logic [15:0] add_dataa,
  output logic [15:0] add_datab,
  input  logic [15:0] add_result,
  input  logic        add_overflow,
  input  logic        add_underflow
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LATENCY);

  typedef enum logic [1:0] {IDLE, READY, ADD, OUT} state_t;

  state_t           state;
  logic [15:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             last_pend;
  logic             ovf;
  logic             unf;
  logic             nan;

  logic in_nan;
  logic res_nan;
  logic ovf_next;
  logic unf_next;
  logic nan_next;

  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

  assign in_nan   = is_nan(in_data);
  assign res_nan  = is_nan(add_result);
  assign ovf_next = ovf | add_overflow;
  assign unf_next = unf | add_underflow;
  assign nan_next = nan | res_nan;

  // Beats are only taken while waiting for a row start or the next operand.
  assign in_ready = reset && ((state == IDLE) || (state == READY));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      last_pend     <= 1'b0;
      ovf           <= 1'b0;
      unf           <= 1'b0;
      nan           <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_nan       <= 1'b0;
      add_clk_en    <= 1'b0;
      add_dataa     <= '0;
      add_datab     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc <= in_data;
            ovf <= 1'b0;
            unf <= 1'b0;
            nan <= in_nan;
            if (in_last) begin
              state         <= OUT;
              out_valid     <= 1'b1;
              out_data      <= in_data;
              out_overflow  <= 1'b0;
              out_underflow <= 1'b0;
              out_nan       <= in_nan;
            end else begin
              state <= READY;
            end
          end
        end
        READY: begin
          if (in_valid) begin
            add_dataa  <= acc;
            add_datab  <= in_data;
            last_pend  <= in_last;
            nan        <= nan | in_nan;
            cnt        <= '0;
            add_clk_en <= 1'b1;
            state      <= ADD;
          end
        end
        ADD: begin
          // The adder result is valid once LATENCY enabled edges have passed.
          if (cnt == CNT_MAX) begin
            acc        <= add_result;
            ovf        <= ovf_next;
            unf        <= unf_next;
            nan        <= nan_next;
            add_clk_en <= 1'b0;
            if (last_pend) begin
              state         <= OUT;
              out_valid     <= 1'b1;
              out_data      <= add_result;
              out_overflow  <= ovf_next;
              out_underflow <= unf_next;
              out_nan       <= nan_next;
            end else begin
              state <= READY;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_nan       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_row_accumulator.sv
// Directed bench for fp16_row_accumulator with a table-driven adder model and
// an expected-result queue popped whenever a row sum appears.
module tb_fp16_row_accumulator;

  localparam int LAT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_nan;
  logic        add_clk_en;
  logic [15:0] add_dataa;
  logic [15:0] add_datab;
  logic [15:0] add_result;
  logic        add_overflow;
  logic        add_underflow;

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
    logic        unf;
    logic        nan;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   ready_viol = 0;
  logic [17:0] pipe [LAT];

  fp16_row_accumulator #(.LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_nan(out_nan),
    .add_clk_en(add_clk_en), .add_dataa(add_dataa), .add_datab(add_datab),
    .add_result(add_result), .add_overflow(add_overflow), .add_underflow(add_underflow)
  );

  always #5 clock = ~clock;

  // Known sums for the vectors used here; {overflow, underflow, result}.
  function automatic logic [17:0] add_model(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h3C00, 16'h4000}: return {2'b00, 16'h4200};
      {16'h4200, 16'h3800}: return {2'b00, 16'h4300};
      {16'h7BFF, 16'h7BFF}: return {2'b10, 16'h7C00};
      {16'h0400, 16'h8200}: return {2'b01, 16'h0200};
      {16'h3C00, 16'h7E00}: return {2'b00, 16'h4500};
      {16'h4500, 16'h4000}: return {2'b00, 16'h4700};
      {16'h7C00, 16'hFC00}: return {2'b00, 16'h7E00};
      default:              return {2'b00, 16'hDEAD};
    endcase
  endfunction

  always @(posedge clock) begin
    if (add_clk_en) begin
      pipe[0] <= add_model(add_dataa, add_datab);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign add_overflow  = pipe[LAT-1][17];
  assign add_underflow = pipe[LAT-1][16];
  assign add_result    = pipe[LAT-1][15:0];

  always @(negedge clock) begin
    if (add_clk_en) en_cnt++;
    if (add_clk_en && in_ready) ready_viol++;
  end

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic o, input logic u, input logic n);
    exp_t e;
    e.data = d; e.ovf = o; e.unf = u; e.nan = n;
    sb.push_back(e);
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 100) begin step(); n++; end
    if (!in_ready) check_output("accept_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic wait_out(input string tag, output int t);
    int n = 0;
    exp_t e;
    while (!out_valid && n < 200) begin step(); n++; end
    t = cyc;
    check_output({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_output({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check_output({tag, "_data"}, 32'(out_data), 32'(e.data));
        check_output({tag, "_flags"}, 32'({out_overflow, out_underflow, out_nan}),
                     32'({e.ovf, e.unf, e.nan}));
      end
    end
  endtask

  initial begin
    int t0, t, e0;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_outs", 32'({out_valid, out_data, out_overflow, out_underflow, out_nan}), 32'd0);
    check_output("rst_add", 32'({add_clk_en, add_dataa, add_datab}), 32'd0);
    reset = 1'b1;
    #1;
    check_output("rel_in_ready", 32'(in_ready), 32'd1);

    // Single beat row: no adder pass, result on the next cycle.
    e0 = en_cnt; t0 = cyc;
    push_exp(16'h3C00, 0, 0, 0);
    send_beat(16'h3C00, 1'b1);
    in_valid = 1'b0;
    wait_out("single", t);
    check_output("single_lat", 32'(t - t0), 32'd1);
    check_output("single_no_en", 32'(en_cnt - e0), 32'd0);
    step();
    check_output("idle_ready", 32'(in_ready), 32'd1);

    // Three beat row with in_valid held high.
    e0 = en_cnt; t0 = cyc;
    push_exp(16'h4300, 0, 0, 0);
    send_beat(16'h3C00, 1'b0);
    send_beat(16'h4000, 1'b0);
    send_beat(16'h3800, 1'b1);
    in_valid = 1'b0;
    wait_out("row3", t);
    check_output("row3_lat", 32'(t - t0), 32'd21);
    check_output("row3_en_cycles", 32'(en_cnt - e0), 32'd18);
    step();
    check_output("operands_held", 32'({add_dataa, add_datab}), {16'h4200, 16'h3800});

    // Overflow, then a clean row to show the flags are per row.
    push_exp(16'h7C00, 1, 0, 0);
    send_beat(16'h7BFF, 1'b0);
    send_beat(16'h7BFF, 1'b1);
    in_valid = 1'b0;
    wait_out("ovf", t);
    step();
    push_exp(16'h3C00, 0, 0, 0);
    send_beat(16'h3C00, 1'b1);
    in_valid = 1'b0;
    wait_out("clear", t);
    step();

    push_exp(16'h0200, 0, 1, 0);
    send_beat(16'h0400, 1'b0);
    send_beat(16'h8200, 1'b1);
    in_valid = 1'b0;
    wait_out("unf", t);
    step();

    // NaN input with a non-NaN adder payload still flags the row.
    push_exp(16'h4700, 0, 0, 1);
    send_beat(16'h3C00, 1'b0);
    send_beat(16'h7E00, 1'b0);
    send_beat(16'h4000, 1'b1);
    in_valid = 1'b0;
    wait_out("nan_in", t);
    step();

    push_exp(16'h7E00, 0, 0, 1);
    send_beat(16'h7C00, 1'b0);
    send_beat(16'hFC00, 1'b1);
    in_valid = 1'b0;
    wait_out("nan_res", t);
    step();

    push_exp(16'h8000, 0, 0, 0);
    send_beat(16'h8000, 1'b1);
    in_valid = 1'b0;
    wait_out("neg_zero", t);
    step();

    push_exp(16'h7D55, 0, 0, 1);
    send_beat(16'h7D55, 1'b1);
    in_valid = 1'b0;
    wait_out("nan_payload", t);
    step();

    // Backpressure: outputs stay put while out_ready is low.
    out_ready = 1'b0;
    push_exp(16'h4200, 0, 0, 0);
    send_beat(16'h3C00, 1'b0);
    send_beat(16'h4000, 1'b1);
    in_valid = 1'b0;
    wait_out("hold", t);
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("hold_stable",
                   32'({out_valid, in_ready, out_overflow, out_underflow, out_nan, out_data}),
                   32'({1'b1, 1'b0, 3'b000, 16'h4200}));
    end
    out_ready = 1'b1;
    step();
    check_output("hold_release", 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));

    // Reset in the middle of an adder pass discards the row.
    send_beat(16'h3C00, 1'b0);
    send_beat(16'h4000, 1'b1);
    in_valid = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    step();
    check_output("midrst_in_ready", 32'(in_ready), 32'd0);
    check_output("midrst_outs", 32'({out_valid, out_data, out_overflow, out_underflow, out_nan}), 32'd0);
    check_output("midrst_add", 32'({add_clk_en, add_dataa, add_datab}), 32'd0);
    reset = 1'b1;
    #1;
    check_output("midrst_rel_ready", 32'(in_ready), 32'd1);
    t = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid || add_clk_en) t++;
      step();
    end
    check_output("midrst_quiet", 32'(t), 32'd0);
    push_exp(16'h4200, 0, 0, 0);
    send_beat(16'h4200, 1'b1);
    in_valid = 1'b0;
    wait_out("after_rst", t);
    step();

    check_output("ready_in_add", 32'(ready_viol), 32'd0);
    check_output("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
